// File: rtl/main.sv
// Four-stage teaching pipeline (IF, IF/ID, ID/EX, EX/MEM) with an internal program ROM
// and register file. Every output is a direct EX/MEM register bit.
module main (
    input  logic        clk,
    input  logic        reset,
    input  logic        Hazard,
    output logic        overflow,
    output logic [15:0] ALUResult_MEM,
    output logic [15:0] R0D_MEM,
    output logic [15:0] DataIn_MEM,
    output logic [3:0]  RA1_MEM,
    output logic [3:0]  opcode_MEM,
    output logic [3:0]  FN_Offset_MEM,
    output logic        regWrite_MEM,
    output logic        r0Write_MEM,
    output logic        memRead_MEM,
    output logic        memWrite_MEM,
    output logic        memSource_MEM
);

    // ALU_ZERO must stay encoding 0 so that an all-zero ID/EX word is a clean bubble.
    typedef enum logic [2:0] {
        ALU_ZERO = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_MUL  = 3'd5,
        ALU_EA   = 3'd6
    } alu_op_t;

    typedef struct packed {
        alu_op_t     alu_op;
        logic [3:0]  opcode;
        logic [3:0]  ra1;
        logic [3:0]  fn;
        logic [15:0] a;
        logic [15:0] b;
        logic        reg_w;
        logic        r0_w;
        logic        mem_r;
        logic        mem_w;
        logic        mem_s;
    } id_ex_t;

    typedef struct packed {
        logic        ovf;
        logic [15:0] alu;
        logic [15:0] r0d;
        logic [15:0] din;
        logic [3:0]  ra1;
        logic [3:0]  opcode;
        logic [3:0]  fn;
        logic        reg_w;
        logic        r0_w;
        logic        mem_r;
        logic        mem_w;
        logic        mem_s;
    } ex_mem_t;

    logic [3:0]  pc;
    logic [15:0] rom_word;
    logic [15:0] if_id;
    logic [15:0] rf [16];
    id_ex_t      dec, id_ex;
    ex_mem_t     ex_res, ex_mem;

    always_comb begin
        rom_word = 16'h0000;
        case (pc)
            4'd0:    rom_word = 16'hF120;
            4'd1:    rom_word = 16'hF341;
            4'd2:    rom_word = 16'hF564;
            4'd3:    rom_word = 16'h8782;
            4'd4:    rom_word = 16'hB9A3;
            4'd5:    rom_word = 16'hFBC2;
            4'd6:    rom_word = 16'hFFF0;
            default: rom_word = 16'h0000;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let later stages see this edge's updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            if_id <= '0;
        end else if (!Hazard) begin
            pc    <= pc + 4'd1;
            if_id <= rom_word;
        end
    end

    // NOTE: the register file is deliberately reset (R[k]=k, R15=7FFF) because the
    // program depends on those seed values; ordinary RAMs are normally left unreset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 15; k++) rf[k] <= 16'(k);
            rf[15] <= 16'h7FFF;
        end else begin
            if (regWrite_MEM && !memRead_MEM) rf[RA1_MEM] <= ALUResult_MEM;
            // Later assignment takes precedence, so the R0 product half wins over RA1=0.
            if (r0Write_MEM) rf[0] <= R0D_MEM;
        end
    end

    // NOTE: every field gets a default before the case so no path infers a latch.
    always_comb begin
        dec        = '0;
        dec.opcode = if_id[15:12];
        dec.ra1    = if_id[11:8];
        dec.fn     = if_id[3:0];
        dec.a      = rf[if_id[11:8]];
        dec.b      = rf[if_id[7:4]];
        case (if_id[15:12])
            4'hF: begin
                case (if_id[3:0])
                    4'd0: begin dec.alu_op = ALU_ADD; dec.reg_w = 1'b1; end
                    4'd1: begin dec.alu_op = ALU_SUB; dec.reg_w = 1'b1; end
                    4'd2: begin dec.alu_op = ALU_AND; dec.reg_w = 1'b1; end
                    4'd3: begin dec.alu_op = ALU_OR;  dec.reg_w = 1'b1; end
                    4'd4: begin
                        dec.alu_op = ALU_MUL;
                        dec.reg_w  = 1'b1;
                        dec.r0_w   = 1'b1;
                    end
                    default: dec.alu_op = ALU_ZERO;
                endcase
            end
            4'h8: begin
                dec.alu_op = ALU_EA;
                dec.mem_r  = 1'b1;
                dec.reg_w  = 1'b1;
                dec.mem_s  = 1'b1;
            end
            4'hB: begin
                dec.alu_op = ALU_EA;
                dec.mem_w  = 1'b1;
            end
            default: dec.alu_op = ALU_ZERO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       id_ex <= '0;
        else if (Hazard) id_ex <= '0;
        else             id_ex <= dec;
    end

    logic [15:0]        sum, diff;
    logic signed [31:0] prod;

    assign sum  = id_ex.a + id_ex.b;
    assign diff = id_ex.a - id_ex.b;
    assign prod = $signed(id_ex.a) * $signed(id_ex.b);

    always_comb begin
        ex_res        = '0;
        ex_res.din    = id_ex.a;
        ex_res.ra1    = id_ex.ra1;
        ex_res.opcode = id_ex.opcode;
        ex_res.fn     = id_ex.fn;
        ex_res.reg_w  = id_ex.reg_w;
        ex_res.r0_w   = id_ex.r0_w;
        ex_res.mem_r  = id_ex.mem_r;
        ex_res.mem_w  = id_ex.mem_w;
        ex_res.mem_s  = id_ex.mem_s;
        case (id_ex.alu_op)
            ALU_ADD: begin
                ex_res.alu = sum;
                ex_res.ovf = (id_ex.a[15] == id_ex.b[15]) && (sum[15] != id_ex.a[15]);
            end
            ALU_SUB: begin
                ex_res.alu = diff;
                ex_res.ovf = (id_ex.a[15] != id_ex.b[15]) && (diff[15] != id_ex.a[15]);
            end
            ALU_AND: ex_res.alu = id_ex.a & id_ex.b;
            ALU_OR:  ex_res.alu = id_ex.a | id_ex.b;
            ALU_MUL: begin
                ex_res.alu = prod[15:0];
                ex_res.r0d = prod[31:16];
            end
            ALU_EA:  ex_res.alu = id_ex.b + {12'h000, id_ex.fn};
            default: ex_res.alu = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ex_mem <= '0;
        else       ex_mem <= ex_res;
    end

    assign overflow      = ex_mem.ovf;
    assign ALUResult_MEM = ex_mem.alu;
    assign R0D_MEM       = ex_mem.r0d;
    assign DataIn_MEM    = ex_mem.din;
    assign RA1_MEM       = ex_mem.ra1;
    assign opcode_MEM    = ex_mem.opcode;
    assign FN_Offset_MEM = ex_mem.fn;
    assign regWrite_MEM  = ex_mem.reg_w;
    assign r0Write_MEM   = ex_mem.r0_w;
    assign memRead_MEM   = ex_mem.mem_r;
    assign memWrite_MEM  = ex_mem.mem_w;
    assign memSource_MEM = ex_mem.mem_s;

endmodule

// File: tb/tb_main.sv
// Bench for main: directed program checks, hazard bubble, async reset, then random
// Hazard/reset traffic compared cycle by cycle against an instruction-level model.
module tb_main;

    logic        clk = 1'b0;
    logic        reset;
    logic        Hazard;
    logic        overflow;
    logic [15:0] ALUResult_MEM, R0D_MEM, DataIn_MEM;
    logic [3:0]  RA1_MEM, opcode_MEM, FN_Offset_MEM;
    logic        regWrite_MEM, r0Write_MEM, memRead_MEM, memWrite_MEM, memSource_MEM;

    main dut (
        .clk(clk), .reset(reset), .Hazard(Hazard), .overflow(overflow),
        .ALUResult_MEM(ALUResult_MEM), .R0D_MEM(R0D_MEM), .DataIn_MEM(DataIn_MEM),
        .RA1_MEM(RA1_MEM), .opcode_MEM(opcode_MEM), .FN_Offset_MEM(FN_Offset_MEM),
        .regWrite_MEM(regWrite_MEM), .r0Write_MEM(r0Write_MEM), .memRead_MEM(memRead_MEM),
        .memWrite_MEM(memWrite_MEM), .memSource_MEM(memSource_MEM)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ovf;
        logic [15:0] alu;
        logic [15:0] r0d;
        logic [15:0] din;
        logic [3:0]  ra1;
        logic [3:0]  op;
        logic [3:0]  fn;
        logic        reg_w;
        logic        r0_w;
        logic        mem_r;
        logic        mem_w;
        logic        mem_s;
    } out_t;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] rom [16];
    logic [15:0] m_regs [16];
    logic [3:0]  m_pc;
    logic [15:0] m_ifid;
    out_t        m_ex, m_mem;

    function automatic out_t observed();
        out_t o;
        o = {overflow, ALUResult_MEM, R0D_MEM, DataIn_MEM, RA1_MEM, opcode_MEM,
             FN_Offset_MEM, regWrite_MEM, r0Write_MEM, memRead_MEM, memWrite_MEM,
             memSource_MEM};
        return o;
    endfunction

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // What the instruction does, straight from the ISA rules, using register values
    // as they stand when it is decoded.
    function automatic out_t predict(input logic [15:0] w);
        out_t o;
        logic [15:0] a, b;
        int s, p;
        o = '0;
        a = m_regs[w[11:8]];
        b = m_regs[w[7:4]];
        o.op = w[15:12];
        o.ra1 = w[11:8];
        o.fn = w[3:0];
        o.din = a;
        if (w[15:12] == 4'hF && w[3:0] <= 4'd4) begin
            o.reg_w = 1'b1;
            case (w[3:0])
                4'd0: begin
                    s = int'($signed(a)) + int'($signed(b));
                    o.alu = 16'(s);
                    o.ovf = (s > 32767) || (s < -32768);
                end
                4'd1: begin
                    s = int'($signed(a)) - int'($signed(b));
                    o.alu = 16'(s);
                    o.ovf = (s > 32767) || (s < -32768);
                end
                4'd2: o.alu = a & b;
                4'd3: o.alu = a | b;
                default: begin
                    p = int'($signed(a)) * int'($signed(b));
                    o.alu = p[15:0];
                    o.r0d = p[31:16];
                    o.r0_w = 1'b1;
                end
            endcase
        end else if (w[15:12] == 4'h8) begin
            o.alu = b + 16'(w[3:0]);
            o.mem_r = 1'b1;
            o.reg_w = 1'b1;
            o.mem_s = 1'b1;
        end else if (w[15:12] == 4'hB) begin
            o.alu = b + 16'(w[3:0]);
            o.mem_w = 1'b1;
        end
        return o;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 15; k++) m_regs[k] = 16'(k);
        m_regs[15] = 16'h7FFF;
        m_pc = 4'd0;
        m_ifid = 16'h0000;
        m_ex = '0;
        m_mem = '0;
    endtask

    task automatic m_edge(input logic hz);
        out_t cap;
        cap = predict(m_ifid);
        if (m_mem.reg_w && !m_mem.mem_r) m_regs[m_mem.ra1] = m_mem.alu;
        if (m_mem.r0_w) m_regs[0] = m_mem.r0d;
        m_mem = m_ex;
        if (hz) begin
            m_ex = '0;
        end else begin
            m_ex = cap;
            m_ifid = rom[m_pc];
            m_pc = m_pc + 4'd1;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        m_edge(Hazard);
        #1;
        check(tag, observed(), m_mem);
    endtask

    // Called just after a step; pulses reset between edges and checks the immediate clear.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check(tag, observed(), 66'd0);
        m_reset();
        #2;
        reset = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) rom[k] = 16'h0000;
        rom[0] = 16'hF120; rom[1] = 16'hF341; rom[2] = 16'hF564; rom[3] = 16'h8782;
        rom[4] = 16'hB9A3; rom[5] = 16'hFBC2; rom[6] = 16'hFFF0;

        reset = 1'b1;
        Hazard = 1'b0;
        m_reset();
        #1;
        check("reset state", observed(), 66'd0);
        #20;
        reset = 1'b0;

        // Program walk with no stalls.
        step("e1");
        step("e2");
        step("e3");
        check("e3 alu", ALUResult_MEM, 16'h0003);
        check("e3 ra1/op", {RA1_MEM, opcode_MEM}, {4'h1, 4'hF});
        check("e3 regw/ovf", {regWrite_MEM, overflow}, 2'b10);
        step("e4");
        check("e4 sub", {ALUResult_MEM, RA1_MEM}, {16'hFFFF, 4'h3});
        step("e5");
        check("e5 mul", {ALUResult_MEM, R0D_MEM, r0Write_MEM}, {16'h001E, 16'h0000, 1'b1});
        step("e6");
        check("e6 lw", {ALUResult_MEM, memRead_MEM, memSource_MEM, regWrite_MEM},
              {16'h000A, 3'b111});
        step("e7");
        check("e7 sw", {ALUResult_MEM, DataIn_MEM, memWrite_MEM, regWrite_MEM},
              {16'h000D, 16'h0009, 2'b10});
        step("e8");
        check("e8 and", ALUResult_MEM, 16'h0008);
        step("e9");
        check("e9 add ovf", {ALUResult_MEM, overflow}, {16'hFFFE, 1'b1});
        step("e10");
        check("e10 nop flags",
              {overflow, regWrite_MEM, r0Write_MEM, memRead_MEM, memWrite_MEM, memSource_MEM},
              6'b0);
        step("e11");

        // Asynchronous reset mid-run, then the program restarts from PC 0.
        do_reset("async reset clear");
        step("r1");
        step("r2");
        step("r3");
        check("restart add", {ALUResult_MEM, RA1_MEM}, {16'h0003, 4'h1});

        // One stall edge right after the first fetch.
        do_reset("reset before hazard");
        step("h1");
        Hazard = 1'b1;
        step("h2");
        Hazard = 1'b0;
        step("h3");
        check("hazard bubble", observed(), 66'd0);
        step("h4");
        check("delayed add", ALUResult_MEM, 16'h0003);
        step("h5");
        check("sub after stall", ALUResult_MEM, 16'hFFFF);

        // Random stalls and occasional resets against the model.
        for (int i = 0; i < 600; i++) begin
            Hazard = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) do_reset("random reset");
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
